// File: rtl/debounce_pkg.sv
// debounce_pkg: arbiter state type, width helper and default parameters for the switch debouncer
package debounce_pkg;
  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} arb_state_t;
  localparam int DEF_NUM_SWITCHES = 4;
  localparam int DEF_TICK_CYCLES  = 2500;
  localparam int DEF_STABLE_TICKS = 100;
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: two-flop synchronizer plus tick-based stability counter for one switch
//   i_Clk, i_Rst_L : clock, async active-low reset
//   i_Switch       : raw switch level
//   i_Tick         : shared sample strobe
//   o_Debounced    : accepted level
//   o_Edge         : combinational strobe, high on the cycle a new level is accepted
//   o_Level        : synchronized level (the new level when o_Edge is high)
module debounce_channel import debounce_pkg::*; #(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  input  logic i_Tick,
  output logic o_Debounced,
  output logic o_Edge,
  output logic o_Level
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  assign w_diff  = r_sync[1] ^ o_Debounced;
  assign o_Edge  = i_Tick && w_diff && (r_cnt == CW'(STABLE_TICKS - 1));
  assign o_Level = r_sync[1];
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) begin
      r_sync      <= '0;
      r_cnt       <= '0;
      o_Debounced <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_Switch};
      if (i_Tick) begin
        r_cnt <= (!w_diff || o_Edge) ? '0 : r_cnt + 1'b1;
        if (o_Edge) o_Debounced <= r_sync[1];
      end
    end
endmodule

// File: rtl/debounce_event_arbiter.sv
// debounce_event_arbiter: debounces switches and delivers edge events round-robin over valid/ready
//   i_Clk, i_Rst_L  : clock, async active-low reset
//   i_Switch        : raw switch levels
//   o_Debounced     : debounced levels
//   o_Event_Valid/Id/Rise, i_Event_Ready : event handshake (Rise=1 for 0->1)
//   o_Drop          : one-cycle pulse when a pending event is overwritten
module debounce_event_arbiter import debounce_pkg::*; #(
  parameter int NUM_SWITCHES = DEF_NUM_SWITCHES,
  parameter int TICK_CYCLES  = DEF_TICK_CYCLES,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int ID_W         = clog2_min1(NUM_SWITCHES)
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_SWITCHES-1:0] i_Switch,
  output logic [NUM_SWITCHES-1:0] o_Debounced,
  output logic                    o_Event_Valid,
  output logic [ID_W-1:0]         o_Event_Id,
  output logic                    o_Event_Rise,
  input  logic                    i_Event_Ready,
  output logic                    o_Drop
);
  localparam int PW = clog2_min1(TICK_CYCLES);
  logic [PW-1:0]           r_presc;
  logic                    w_tick;
  logic [NUM_SWITCHES-1:0] w_edge, w_level, w_clr, r_pend, r_rise;
  arb_state_t              r_state, w_next;
  logic                    w_found, w_load, w_done;
  logic [ID_W-1:0]         w_grant, r_last_grant;
  int                      w_dist, w_best;
  assign w_tick = r_presc == PW'(TICK_CYCLES - 1);
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) r_presc <= '0;
    else r_presc <= w_tick ? '0 : r_presc + 1'b1;
  for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_ch
    debounce_channel #(.STABLE_TICKS(STABLE_TICKS)) u_ch (
      .i_Clk       (i_Clk),
      .i_Rst_L     (i_Rst_L),
      .i_Switch    (i_Switch[i]),
      .i_Tick      (w_tick),
      .o_Debounced (o_Debounced[i]),
      .o_Edge      (w_edge[i]),
      .o_Level     (w_level[i])
    );
  end
  // Round-robin pick: the pending channel closest after last_grant (distance 0 = last_grant+1).
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_best  = NUM_SWITCHES;
    w_dist  = 0;
    for (int k = 0; k < NUM_SWITCHES; k++) begin
      w_dist = (k + 2 * NUM_SWITCHES - 1 - int'(r_last_grant)) % NUM_SWITCHES;
      if (r_pend[k] && w_dist < w_best) begin
        w_best  = w_dist;
        w_grant = ID_W'(k);
        w_found = 1'b1;
      end
    end
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = (r_state == IDLE) ? (w_found ? PRESENT : IDLE) : (i_Event_Ready ? IDLE : PRESENT);
  always_comb begin
    w_load = (r_state == IDLE) && w_found;
    w_done = (r_state == PRESENT) && i_Event_Ready;
  end
  assign w_clr = NUM_SWITCHES'(w_load) << w_grant;
  // A new edge beats a same-cycle grant clear, and that collision is not counted as a drop.
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) begin
      r_pend        <= '0;
      r_rise        <= '0;
      o_Drop        <= 1'b0;
      o_Event_Valid <= 1'b0;
      o_Event_Id    <= '0;
      o_Event_Rise  <= 1'b0;
      r_last_grant  <= ID_W'(NUM_SWITCHES - 1);
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_edge;
      r_rise <= (r_rise & ~w_edge) | (w_level & w_edge);
      o_Drop <= |(w_edge & r_pend & ~w_clr);
      if (w_load) begin
        o_Event_Valid <= 1'b1;
        o_Event_Id    <= w_grant;
        o_Event_Rise  <= r_rise[w_grant];
        r_last_grant  <= w_grant;
      end else if (w_done) o_Event_Valid <= 1'b0;
    end
endmodule
